lcd_timing_pattern: RTL and testbench

- Parametrised successor of the fixed 800x480 LCD timing generator.
- Timing fields are configurable, sync polarity is selectable, and the block adds a built-in test-pattern engine with run-time mode select, a frame counter, and line/frame strobes.
- It sits between the PLL pixel clock and the RGB LCD pins.
- All outputs are registered and mutually aligned.

---
 rtl/lcd_timing_pattern.sv | 191 +++++++++++++++++++
 tb/tb_lcd_timing_pattern.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_pattern.sv
// Parametrised RGB LCD timing generator with built-in test-pattern engine.
// Outputs are registered once and mutually aligned to the previous cycle's counter state.
module lcd_timing_pattern #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 210,
  parameter int unsigned H_SYNC   = 4,
  parameter int unsigned H_BP     = 42,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 22,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 19,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = 11,
  parameter int unsigned R_W      = 5,
  parameter int unsigned G_W      = 6,
  parameter int unsigned B_W      = 5,
  parameter int unsigned CHK_LOG2 = 4
) (
  input  logic           CLK,
  input  logic           nRST,
  input  logic [1:0]     MODE,
  output logic           HSYNC,
  output logic           VSYNC,
  output logic           DE,
  output logic [CW-1:0]  X,
  output logic [CW-1:0]  Y,
  output logic [R_W-1:0] R,
  output logic [G_W-1:0] G,
  output logic [B_W-1:0] B,
  output logic           LINE_START,
  output logic           FRAME_START,
  output logic [7:0]     FRAME_CNT
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned BAR_W   = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] BAR_LAST   = CW'(BAR_W - 1);

  typedef enum logic [1:0] {
    MODE_BLACK    = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_GRADIENT = 2'd3
  } mode_e;

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic [CW-1:0] bar_px;
  logic [2:0]    bar_idx;
  logic [7:0]    frame_cnt;
  mode_e         mode_q;

  logic          h_wrap_c;
  logic          v_wrap_c;
  logic          origin_c;
  logic          de_c;
  logic          hs_c;
  logic          vs_c;
  logic          ls_c;
  mode_e         mode_c;
  logic [R_W-1:0] r_c;
  logic [G_W-1:0] g_c;
  logic [B_W-1:0] b_c;

  // Position decode; a new MODE takes effect on the very pixel that latches it.
  always_comb begin
    h_wrap_c = (h_cnt == H_LAST);
    v_wrap_c = (v_cnt == V_LAST);
    origin_c = (h_cnt == '0) && (v_cnt == '0);
    de_c     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_c     = (h_cnt >= H_HS_START) && (h_cnt < H_HS_END);
    vs_c     = (v_cnt >= V_VS_START) && (v_cnt < V_VS_END);
    ls_c     = (h_cnt == '0) && (v_cnt < V_ACT);
    mode_c   = origin_c ? mode_e'(MODE) : mode_q;
  end

  // Pattern engine; colour is forced to black outside the active window.
  always_comb begin
    r_c = '0;
    g_c = '0;
    b_c = '0;
    if (de_c) begin
      case (mode_c)
        MODE_BARS: begin
          // bar index bits map directly onto the white..black bar order
          r_c = {R_W{~bar_idx[1]}};
          g_c = {G_W{~bar_idx[2]}};
          b_c = {B_W{~bar_idx[0]}};
        end
        MODE_CHECKER: begin
          if (h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]) begin
            r_c = '1;
            g_c = '1;
            b_c = '1;
          end
        end
        MODE_GRADIENT: begin
          r_c = R_W'(h_cnt);
          g_c = G_W'(v_cnt);
          b_c = B_W'(frame_cnt);
        end
        default: begin
          r_c = '0;
          g_c = '0;
          b_c = '0;
        end
      endcase
    end
  end

  // Raster counters, bar tracker, mode latch and frame counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      bar_px    <= '0;
      bar_idx   <= 3'd0;
      frame_cnt <= 8'd0;
      mode_q    <= MODE_BLACK;
    end else begin
      if (h_wrap_c) begin
        h_cnt <= '0;
        v_cnt <= v_wrap_c ? '0 : v_cnt + CW'(1);
      end else begin
        h_cnt <= h_cnt + CW'(1);
      end

      if (h_wrap_c) begin
        bar_px  <= '0;
        bar_idx <= 3'd0;
      end else if (h_cnt < H_ACT) begin
        // remainder pixels stay in the last bar
        if (bar_px == BAR_LAST && bar_idx != 3'd7) begin
          bar_px  <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else if (bar_px != BAR_LAST) begin
          bar_px <= bar_px + CW'(1);
        end
      end

      if (origin_c) begin
        mode_q <= mode_e'(MODE);
      end

      if (h_wrap_c && v_wrap_c) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Single output register stage keeps every pin aligned.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      HSYNC       <= ~HS_POL;
      VSYNC       <= ~VS_POL;
      DE          <= 1'b0;
      X           <= '0;
      Y           <= '0;
      R           <= '0;
      G           <= '0;
      B           <= '0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
      FRAME_CNT   <= 8'd0;
    end else begin
      HSYNC       <= hs_c ? HS_POL : ~HS_POL;
      VSYNC       <= vs_c ? VS_POL : ~VS_POL;
      DE          <= de_c;
      X           <= de_c ? h_cnt : '0;
      Y           <= de_c ? v_cnt : '0;
      R           <= r_c;
      G           <= g_c;
      B           <= b_c;
      LINE_START  <= ls_c;
      FRAME_START <= origin_c;
      FRAME_CNT   <= frame_cnt;
    end
  end

endmodule

// File: tb/tb_lcd_timing_pattern.sv
// Scoreboard bench for lcd_timing_pattern on a 24x8 raster (16x4 active),
// with a second instance built for active-high sync polarity.
module tb_lcd_timing_pattern;

  localparam int unsigned CW  = 6;
  localparam int unsigned R_W = 5;
  localparam int unsigned G_W = 6;
  localparam int unsigned B_W = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] mode = 2'd0;

  logic           hsync, vsync, de, ls, fs;
  logic [CW-1:0]  x, y;
  logic [R_W-1:0] r;
  logic [G_W-1:0] g;
  logic [B_W-1:0] b;
  logic [7:0]     fc;

  logic           hsync2, vsync2, de2, ls2, fs2;
  logic [CW-1:0]  x2, y2;
  logic [R_W-1:0] r2;
  logic [G_W-1:0] g2;
  logic [B_W-1:0] b2;
  logic [7:0]     fc2;

  lcd_timing_pattern #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW),
    .R_W(R_W), .G_W(G_W), .B_W(B_W), .CHK_LOG2(1)
  ) dut (
    .CLK(clk), .nRST(rst_n), .MODE(mode),
    .HSYNC(hsync), .VSYNC(vsync), .DE(de), .X(x), .Y(y),
    .R(r), .G(g), .B(b), .LINE_START(ls), .FRAME_START(fs), .FRAME_CNT(fc)
  );

  lcd_timing_pattern #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW),
    .R_W(R_W), .G_W(G_W), .B_W(B_W), .CHK_LOG2(1)
  ) dut_pol (
    .CLK(clk), .nRST(rst_n), .MODE(mode),
    .HSYNC(hsync2), .VSYNC(vsync2), .DE(de2), .X(x2), .Y(y2),
    .R(r2), .G(g2), .B(b2), .LINE_START(ls2), .FRAME_START(fs2), .FRAME_CNT(fc2)
  );

  always #5 clk = ~clk;

  typedef enum int {
    S_DE, S_HS, S_VS, S_X, S_Y, S_R, S_G, S_B, S_LS, S_FS, S_FC, S_HS2, S_VS2,
    A_DE, A_HS, A_VS, A_RGB0, A_RGB3, A_SHAPE
  } sig_e;

  typedef struct {
    int   epoch;
    int   cyc;
    sig_e sig;
    int   val;
  } exp_t;

  exp_t exp_q[$];

  int cyc = 0;
  int epoch = 0;
  int vectors = 0;
  int miscompares = 0;
  int agg_de = 0, agg_hs = 0, agg_vs = 0, agg_rgb0 = 0, agg_rgb3 = 0, shape_err = 0;
  bit final_check = 1'b0;
  bit done = 1'b0;

  // Clock edges since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int sample(input sig_e s);
    case (s)
      S_DE:    return int'(de);
      S_HS:    return int'(hsync);
      S_VS:    return int'(vsync);
      S_X:     return int'(x);
      S_Y:     return int'(y);
      S_R:     return int'(r);
      S_G:     return int'(g);
      S_B:     return int'(b);
      S_LS:    return int'(ls);
      S_FS:    return int'(fs);
      S_FC:    return int'(fc);
      S_HS2:   return int'(hsync2);
      S_VS2:   return int'(vsync2);
      A_DE:    return agg_de;
      A_HS:    return agg_hs;
      A_VS:    return agg_vs;
      A_RGB0:  return agg_rgb0;
      A_RGB3:  return agg_rgb3;
      A_SHAPE: return shape_err;
      default: return -1;
    endcase
  endfunction

  // Expectations are kept ordered by (epoch, cycle).
  task automatic expect_at(input int ep, input int c, input sig_e s, input int v);
    exp_t e;
    int i;
    e = '{ep, c, s, v};
    i = 0;
    while (i < exp_q.size() &&
           (exp_q[i].epoch < ep || (exp_q[i].epoch == ep && exp_q[i].cyc <= c))) i++;
    exp_q.insert(i, e);
  endtask

  task automatic expect_rgb(input int c, input int rv, input int gv, input int bv);
    expect_at(0, c, S_R, rv);
    expect_at(0, c, S_G, gv);
    expect_at(0, c, S_B, bv);
  endtask

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < n) begin
      $display("FAIL wait_cyc: reached cycle %0d, required %0d", cyc, n);
      $fatal(1, "bench stalled");
    end
  endtask

  exp_t cur;
  int   act, hp, vp;
  bit   ok, hs_a, vs_a, de_e;

  // Monitor: pop due expectations, then fold this cycle into the raster checks.
  always @(negedge clk) begin
    while (exp_q.size() > 0 &&
           (exp_q[0].epoch < epoch || (exp_q[0].epoch == epoch && exp_q[0].cyc <= cyc))) begin
      cur = exp_q.pop_front();
      vectors++;
      if (cur.epoch != epoch || cur.cyc != cyc) begin
        miscompares++;
        $display("FAIL %s: slot epoch %0d cycle %0d was skipped (now epoch %0d cycle %0d)",
                 cur.sig.name(), cur.epoch, cur.cyc, epoch, cyc);
      end else begin
        act = sample(cur.sig);
        if (act != cur.val) begin
          miscompares++;
          $display("FAIL %s @epoch %0d cycle %0d: got %0d, expected %0d",
                   cur.sig.name(), epoch, cyc, act, cur.val);
        end
      end
    end

    if (epoch == 0 && cyc >= 1 && cyc <= 192) begin
      agg_de += int'(de);
      if (!hsync) agg_hs++;
      if (!vsync) agg_vs++;
      if (r != '0 || g != '0 || b != '0) agg_rgb0++;
    end
    if (epoch == 0 && cyc >= 577 && cyc <= 768) begin
      if (r != '0 || g != '0 || b != '0) agg_rgb3++;
    end

    if (cyc >= 1) begin
      hp   = (cyc - 1) % 24;
      vp   = ((cyc - 1) / 24) % 8;
      hs_a = (hp >= 18 && hp <= 20);
      vs_a = (vp >= 5 && vp <= 6);
      de_e = (hp < 16 && vp < 4);
      ok = (hsync == !hs_a) && (vsync == !vs_a) && (hsync2 == hs_a) && (vsync2 == vs_a) &&
           (de == de_e) && (de2 == de_e) &&
           (ls == (hp == 0 && vp < 4)) && (ls2 == (hp == 0 && vp < 4)) &&
           (fs == (hp == 0 && vp == 0)) && (fs2 == (hp == 0 && vp == 0)) &&
           (int'(x) == (de_e ? hp : 0)) && (int'(x2) == (de_e ? hp : 0)) &&
           (int'(y) == (de_e ? vp : 0)) && (int'(y2) == (de_e ? vp : 0)) &&
           (int'(fc) == ((cyc - 1) / 192) % 256) && (int'(fc2) == ((cyc - 1) / 192) % 256);
      if (epoch == 0 && cyc <= 192) ok = ok && (r2 == '0) && (g2 == '0) && (b2 == '0);
      if (!ok) shape_err++;
    end

    if (final_check && !done) begin
      while (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL %s: epoch %0d cycle %0d never checked", cur.sig.name(), cur.epoch, cur.cyc);
      end
      done = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;

    // Reset values and the first frame with MODE=0.
    expect_at(0, 0, S_DE, 0);   expect_at(0, 0, S_HS, 1);   expect_at(0, 0, S_VS, 1);
    expect_at(0, 0, S_X, 0);    expect_at(0, 0, S_FS, 0);   expect_at(0, 0, S_FC, 0);
    expect_at(0, 0, S_R, 0);    expect_at(0, 0, S_HS2, 0);
    expect_at(0, 1, S_FS, 1);   expect_at(0, 1, S_LS, 1);   expect_at(0, 1, S_DE, 1);
    expect_at(0, 2, S_FS, 0);
    expect_at(0, 16, S_DE, 1);  expect_at(0, 17, S_DE, 0);
    expect_at(0, 18, S_HS, 1);  expect_at(0, 19, S_HS, 0);  expect_at(0, 19, S_HS2, 1);
    expect_at(0, 21, S_HS, 0);  expect_at(0, 21, S_X, 0);   expect_at(0, 22, S_HS, 1);
    expect_at(0, 25, S_LS, 1);  expect_at(0, 80, S_X, 7);   expect_at(0, 80, S_Y, 3);
    expect_at(0, 97, S_LS, 0);
    expect_at(0, 120, S_VS, 1); expect_at(0, 121, S_VS, 0); expect_at(0, 121, S_VS2, 1);
    expect_at(0, 168, S_VS, 0); expect_at(0, 169, S_VS, 1);
    expect_at(0, 192, S_FC, 0); expect_at(0, 193, S_FS, 1); expect_at(0, 193, S_FC, 1);
    expect_at(0, 193, A_DE, 64); expect_at(0, 193, A_HS, 24);
    expect_at(0, 193, A_VS, 48); expect_at(0, 193, A_RGB0, 0);

    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Colour bars from frame 1 (mid-frame change must not touch frame 0).
    wait_cyc(150);
    mode = 2'd1;
    expect_rgb(193, 31, 63, 31);
    expect_rgb(197, 0, 63, 31);
    expect_at(0, 208, S_G, 0);
    expect_at(0, 211, S_R, 0);
    expect_rgb(220, 31, 63, 0);
    expect_rgb(227, 31, 0, 0);
    expect_at(0, 242, S_G, 63);
    expect_at(0, 243, S_R, 31);
    expect_at(0, 243, S_B, 0);
    expect_at(0, 253, S_R, 0);
    expect_at(0, 253, S_B, 31);
    expect_rgb(279, 0, 0, 0);
    expect_rgb(313, 0, 0, 0);

    // Checkerboard in frame 2.
    wait_cyc(300);
    mode = 2'd2;
    expect_at(0, 385, S_G, 0);
    expect_rgb(387, 31, 63, 31);
    expect_at(0, 433, S_R, 31);
    expect_at(0, 435, S_R, 0);

    // Frame 3 black, then MODE=3 requested on its line 2.
    wait_cyc(500);
    mode = 2'd0;
    expect_rgb(654, 0, 0, 0);
    expect_at(0, 768, S_FC, 3);
    expect_at(0, 769, S_FC, 4);
    expect_at(0, 769, A_RGB3, 0);

    wait_cyc(625);
    mode = 2'd3;
    expect_rgb(832, 15, 2, 4);
    expect_rgb(846, 5, 3, 4);
    expect_at(0, 846, S_FC, 4);
    expect_at(0, 1015, S_DE, 1);
    expect_at(0, 1015, S_X, 6);
    expect_at(0, 1015, S_R, 6);
    expect_at(0, 1015, S_B, 5);
    expect_at(0, 1015, S_FC, 5);

    // Reset in line 2 of frame 5; checker mode requested for the restart.
    wait_cyc(1015);
    mode = 2'd2;
    expect_at(1, 0, S_HS, 1);   expect_at(1, 0, S_VS, 1);   expect_at(1, 0, S_DE, 0);
    expect_at(1, 0, S_X, 0);    expect_at(1, 0, S_Y, 0);    expect_at(1, 0, S_R, 0);
    expect_at(1, 0, S_G, 0);    expect_at(1, 0, S_B, 0);    expect_at(1, 0, S_FS, 0);
    expect_at(1, 0, S_LS, 0);   expect_at(1, 0, S_FC, 0);
    expect_at(1, 0, S_HS2, 0);  expect_at(1, 0, S_VS2, 0);
    expect_at(1, 1, S_FS, 1);   expect_at(1, 1, S_LS, 1);   expect_at(1, 1, S_DE, 1);
    expect_at(1, 1, S_FC, 0);   expect_at(1, 1, S_X, 0);    expect_at(1, 2, S_FS, 0);
    expect_at(1, 3, S_R, 31);   expect_at(1, 3, S_G, 63);
    expect_at(1, 193, S_FS, 1); expect_at(1, 193, S_FC, 1);
    expect_at(1, 200, A_SHAPE, 0);

    @(posedge clk);
    #3 rst_n = 1'b0;
    epoch = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    wait_cyc(201);
    final_check = 1'b1;
    guard = 0;
    while (!done && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!done) begin
      $display("FAIL final_drain: scoreboard did not drain, got %0d pending, expected 0", exp_q.size());
      $fatal(1, "scoreboard stalled");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
